// File: rtl/inst_cache_pkg.sv
// Shared constants and types for the instruction cache slice.
package inst_cache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INDEX_BITS = 7;

    localparam logic True      = 1'b1;
    localparam logic False     = 1'b0;
    localparam logic RstEnable = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Direct-mapped valid/tag/data storage: one combinational lookup port and one
// fill port. Addresses are word addresses (byte offset already stripped).
module inst_cache_array import inst_cache_pkg::*; #(
    parameter int unsigned ADDR_W     = inst_cache_pkg::ADDR_W,
    parameter int unsigned INDEX_BITS = inst_cache_pkg::INDEX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-3:0] rd_wa_i,
    output logic              rd_hit_o,
    output logic [31:0]       rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-3:0] wr_wa_i,
    input  logic [31:0]       wr_data_i
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]      rd_tag, wr_tag;

    assign rd_idx = rd_wa_i[INDEX_BITS-1:0];
    assign rd_tag = rd_wa_i[ADDR_W-3:INDEX_BITS];
    assign wr_idx = wr_wa_i[INDEX_BITS-1:0];
    assign wr_tag = wr_wa_i[ADDR_W-3:INDEX_BITS];

    // Lookup reads the pre-fill contents; a same-cycle fill is visible next cycle.
    always_comb begin
        rd_hit_o  = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_data_o = data_mem[rd_idx];
    end

    // Every fill marks its line valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx] = True;
        end
    end

    // Valid bits clear on reset; reset wins over a coincident fill.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between IF and the byte-serial memory
// controller: 1-cycle hits, miss fill with forward, redirect and flush handling.
module inst_cache import inst_cache_pkg::*; #(
    parameter int unsigned ADDR_W     = inst_cache_pkg::ADDR_W,
    parameter int unsigned INDEX_BITS = inst_cache_pkg::INDEX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              flush_i,
    output logic              if_ok_o,
    output logic [31:0]       if_inst_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic              mem_fe_o,
    output logic [ADDR_W-1:0] mem_fpc_o,
    input  logic              mem_inst_ok_i,
    input  logic [31:0]       mem_inst_i,
    input  logic [ADDR_W-1:0] mem_inst_pc_i
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] miss_pc_q, miss_pc_d;
    logic              if_ok_q, if_ok_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              mem_fe_q, mem_fe_d;
    logic [ADDR_W-1:0] mem_fpc_q, mem_fpc_d;

    logic              lookup_hit;
    logic [31:0]       lookup_data;

    logic              in_miss, complete, serve_hit, start_miss, forward;

    inst_cache_array #(
        .ADDR_W     (ADDR_W),
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_wa_i   (if_pc_i[ADDR_W-1:2]),
        .rd_hit_o  (lookup_hit),
        .rd_data_o (lookup_data),
        .wr_en_i   (mem_inst_ok_i),
        .wr_wa_i   (mem_inst_pc_i[ADDR_W-1:2]),
        .wr_data_i (mem_inst_i)
    );

    // Classify this cycle's event. A flush makes the cycle behave as IDLE, so a
    // matching return is filled but never forwarded. A request that misses on
    // the very PC being completed is not a redirect: the returning word serves it.
    always_comb begin
        in_miss    = (state_q == S_MISS) && !flush_i;
        complete   = in_miss && mem_inst_ok_i && (mem_inst_pc_i == miss_pc_q);
        serve_hit  = if_req_i && lookup_hit;
        start_miss = if_req_i && !lookup_hit && !(complete && (if_pc_i == miss_pc_q));
        forward    = complete && !serve_hit && !start_miss;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= S_IDLE;
            miss_pc_q <= '0;
            if_ok_q   <= False;
            if_inst_q <= '0;
            if_pc_q   <= '0;
            mem_fe_q  <= False;
            mem_fpc_q <= '0;
        end else begin
            state_q   <= state_d;
            miss_pc_q <= miss_pc_d;
            if_ok_q   <= if_ok_d;
            if_inst_q <= if_inst_d;
            if_pc_q   <= if_pc_d;
            mem_fe_q  <= mem_fe_d;
            mem_fpc_q <= mem_fpc_d;
        end
    end

    // Next state and the PC of the outstanding miss.
    always_comb begin
        state_d   = state_q;
        miss_pc_d = miss_pc_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end
        if (serve_hit || forward) begin
            state_d = S_IDLE;
        end else if (start_miss) begin
            state_d   = S_MISS;
            miss_pc_d = if_pc_i;
        end
    end

    // Next values of the IF response and the controller fetch request.
    always_comb begin
        if_ok_d   = False;
        if_inst_d = if_inst_q;
        if_pc_d   = if_pc_q;
        mem_fe_d  = mem_fe_q;
        mem_fpc_d = mem_fpc_q;
        if (flush_i) begin
            mem_fe_d = False;
        end
        if (serve_hit) begin
            if_ok_d   = True;
            if_inst_d = lookup_data;
            if_pc_d   = if_pc_i;
            mem_fe_d  = False;
        end else if (start_miss) begin
            mem_fe_d  = True;
            mem_fpc_d = if_pc_i;
        end else if (forward) begin
            if_ok_d   = True;
            if_inst_d = mem_inst_i;
            if_pc_d   = miss_pc_q;
            mem_fe_d  = False;
        end
    end

    assign if_ok_o   = if_ok_q;
    assign if_inst_o = if_inst_q;
    assign if_pc_o   = if_pc_q;
    assign mem_fe_o  = mem_fe_q;
    assign mem_fpc_o = mem_fpc_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus a randomized
// fetch stream checked against a line-occupancy model of the cache.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        flush_i;
    logic        if_ok_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        mem_fe_o;
    logic [31:0] mem_fpc_o;
    logic        mem_inst_ok_i;
    logic [31:0] mem_inst_i;
    logic [31:0] mem_inst_pc_i;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: which word-aligned PC each line currently holds, and its word.
    logic [31:0] line_pc   [int];
    logic [31:0] line_word [int];

    logic [97:0] obs;

    inst_cache #(
        .ADDR_W     (32),
        .INDEX_BITS (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_pc_i       (if_pc_i),
        .flush_i       (flush_i),
        .if_ok_o       (if_ok_o),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o),
        .mem_fe_o      (mem_fe_o),
        .mem_fpc_o     (mem_fpc_o),
        .mem_inst_ok_i (mem_inst_ok_i),
        .mem_inst_i    (mem_inst_i),
        .mem_inst_pc_i (mem_inst_pc_i)
    );

    always #5 clk = ~clk;

    // Output view: data fields only matter while their strobe is high.
    function automatic logic [97:0] view(input logic ok, input logic [31:0] inst,
                                         input logic [31:0] pc, input logic fe,
                                         input logic [31:0] fpc);
        return {ok, ok ? inst : 32'h0, ok ? pc : 32'h0, fe, fe ? fpc : 32'h0};
    endfunction

    assign obs = view(if_ok_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o);

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[8:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return line_pc.exists(idx_of(pc)) && (line_pc[idx_of(pc)] == pc);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) + 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle IF strobe; outputs afterwards reflect the cycle it was seen.
    task automatic req(input logic [31:0] pc);
        if_req_i = 1'b1;
        if_pc_i  = pc;
        tick();
        if_req_i = 1'b0;
    endtask

    // One-cycle controller return; every return fills its line.
    task automatic ret(input logic [31:0] pc, input logic [31:0] word, input logic flush);
        mem_inst_ok_i = 1'b1;
        mem_inst_pc_i = pc;
        mem_inst_i    = word;
        flush_i       = flush;
        line_pc[idx_of(pc)]   = pc;
        line_word[idx_of(pc)] = word;
        tick();
        mem_inst_ok_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        line_pc.delete();
        line_word.delete();
        tests_run++;
        if ({if_ok_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o} !== 98'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ok=%b inst=%h pc=%h fe=%b fpc=%h, want all zero",
                     if_ok_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o);
        end
    endtask

    task automatic test_miss_fill();
        req(32'h0);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h0)) begin
            tests_failed++; $display("FAIL miss0_request: got %h want fe=1 fpc=0", obs);
        end
        tick();
        tick();
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h0)) begin
            tests_failed++; $display("FAIL miss0_hold: got %h want fe=1 fpc=0", obs);
        end
        ret(32'h0, 32'h0000_0093, 1'b0);
        tests_run++;
        if (obs !== view(1'b1, 32'h0000_0093, 32'h0, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL miss0_forward: got %h want ok=1 inst=00000093 pc=0", obs);
        end
        tick();
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL miss0_single_pulse: got %h want idle", obs);
        end
    endtask

    task automatic test_hit_b2b();
        req(32'h0);
        tests_run++;
        if (obs !== view(1'b1, 32'h0000_0093, 32'h0, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL hit0_latency: got %h want ok=1 inst=00000093", obs);
        end
        req(32'h4);
        ret(32'h4, mem_word(32'h4), 1'b0);
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h4), 32'h4, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL miss4_forward: got %h want ok=1 pc=4", obs);
        end
        if_req_i = 1'b1;
        if_pc_i  = 32'h0;
        tick();
        tests_run++;
        if (obs !== view(1'b1, 32'h0000_0093, 32'h0, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL b2b_first: got %h want ok=1 pc=0", obs);
        end
        if_pc_i = 32'h4;
        tick();
        if_req_i = 1'b0;
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h4), 32'h4, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL b2b_second: got %h want ok=1 pc=4", obs);
        end
        tick();
    endtask

    task automatic test_alias();
        req(32'h200);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h200)) begin
            tests_failed++; $display("FAIL alias_200_miss: got %h want fe=1 fpc=200", obs);
        end
        ret(32'h200, mem_word(32'h200), 1'b0);
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h200), 32'h200, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL alias_200_forward: got %h want ok=1 pc=200", obs);
        end
        req(32'h0);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h0)) begin
            tests_failed++; $display("FAIL alias_0_evicted: got %h want fe=1 fpc=0", obs);
        end
        ret(32'h0, 32'h0000_0093, 1'b0);
        tick();
    endtask

    task automatic test_redirect();
        req(32'h100);
        tick();
        req(32'h300);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h300)) begin
            tests_failed++; $display("FAIL redirect_retarget: got %h want fe=1 fpc=300", obs);
        end
        ret(32'h100, mem_word(32'h100), 1'b0);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h300)) begin
            tests_failed++; $display("FAIL redirect_stale_no_forward: got %h want ok=0 fe=1 fpc=300", obs);
        end
        req(32'h100);
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h100), 32'h100, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL redirect_stale_filled_hit: got %h want ok=1 pc=100", obs);
        end
        req(32'h300);
        ret(32'h300, mem_word(32'h300), 1'b0);
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h300), 32'h300, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL redirect_300_forward: got %h want ok=1 pc=300", obs);
        end
        tick();
    endtask

    task automatic test_flush_fill();
        req(32'h40);
        ret(32'h40, mem_word(32'h40), 1'b1);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL flush_suppress: got %h want ok=0 fe=0", obs);
        end
        req(32'h40);
        tests_run++;
        if (obs !== view(1'b1, mem_word(32'h40), 32'h40, 1'b0, 32'h0)) begin
            tests_failed++; $display("FAIL flush_fill_hit: got %h want ok=1 pc=40", obs);
        end
        tick();
    endtask

    task automatic test_reset_mid_miss();
        req(32'h800);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h800)) begin
            tests_failed++; $display("FAIL rstmid_miss: got %h want fe=1 fpc=800", obs);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        line_pc.delete();
        line_word.delete();
        tests_run++;
        if ({if_ok_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o} !== 98'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got ok=%b inst=%h pc=%h fe=%b fpc=%h, want all zero",
                     if_ok_o, if_inst_o, if_pc_o, mem_fe_o, mem_fpc_o);
        end
        req(32'h4);
        tests_run++;
        if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, 32'h4)) begin
            tests_failed++; $display("FAIL rstmid_invalidated: got %h want fe=1 fpc=4", obs);
        end
        ret(32'h4, mem_word(32'h4), 1'b0);
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc, pc2;
        int unsigned wait_cycles;
        for (int n = 0; n < 200; n++) begin
            pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2);
            if (model_hit(pc)) begin
                req(pc);
                tests_run++;
                if (obs !== view(1'b1, line_word[idx_of(pc)], pc, 1'b0, 32'h0)) begin
                    tests_failed++; $display("FAIL rand_hit pc=%h: got %h", pc, obs);
                end
            end else begin
                req(pc);
                tests_run++;
                if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, pc)) begin
                    tests_failed++; $display("FAIL rand_miss pc=%h: got %h", pc, obs);
                end
                wait_cycles = $urandom_range(0, 3);
                for (int w = 0; w < int'(wait_cycles); w++) begin
                    tick();
                    tests_run++;
                    if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, pc)) begin
                        tests_failed++; $display("FAIL rand_miss_hold pc=%h: got %h", pc, obs);
                    end
                end
                if ($urandom_range(0, 2) == 0) begin
                    pc2 = ($urandom_range(0, 1) == 0) ? (pc ^ 32'h200) : (pc ^ 32'h4);
                    ret(pc2, mem_word(pc2), 1'b0);
                    tests_run++;
                    if (obs !== view(1'b0, 32'h0, 32'h0, 1'b1, pc)) begin
                        tests_failed++; $display("FAIL rand_stale pc=%h stale=%h: got %h", pc, pc2, obs);
                    end
                end
                ret(pc, mem_word(pc), 1'b0);
                tests_run++;
                if (obs !== view(1'b1, mem_word(pc), pc, 1'b0, 32'h0)) begin
                    tests_failed++; $display("FAIL rand_forward pc=%h: got %h", pc, obs);
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                tick();
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        if_req_i      = 1'b0;
        if_pc_i       = 32'h0;
        flush_i       = 1'b0;
        mem_inst_ok_i = 1'b0;
        mem_inst_i    = 32'h0;
        mem_inst_pc_i = 32'h0;
        test_reset();
        test_miss_fill();
        test_hit_b2b();
        test_alias();
        test_redirect();
        test_flush_fill();
        test_reset_mid_miss();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
